// File: rtl/csa_stream_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : csa_stream_accumulator
// Brief    : Streams operands into carry-save sum/carry registers, resolves once per group.
// Revision : 1.0 - initial release
// ============================================================================
module csa_stream_accumulator #(
   parameter int WIDTH     = 8,
   parameter int NUM_OPS   = 10,
   parameter int SUM_WIDTH = WIDTH + $clog2(NUM_OPS),
   parameter int CNT_WIDTH = $clog2(NUM_OPS + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SUM_WIDTH-1:0] out_sum,
   output logic                 out_co,
   output logic [CNT_WIDTH-1:0] out_count
);

   localparam int                   c_acc_w    = WIDTH + $clog2(NUM_OPS) + 1;
   localparam logic [CNT_WIDTH-1:0] c_last_cnt = CNT_WIDTH'(NUM_OPS - 1);

   typedef enum logic [1:0] {
      ST_ACCUM   = 2'd0,
      ST_RESOLVE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_acc_w-1:0]   r_cs_sum;
   logic [c_acc_w-1:0]   r_cs_carry;
   logic [CNT_WIDTH-1:0] r_count;
   logic [SUM_WIDTH-1:0] r_out_sum;
   logic                 r_out_co;
   logic [CNT_WIDTH-1:0] r_out_count;

   logic                 w_accept;
   logic                 w_close;
   logic                 w_xfer;
   logic [c_acc_w-1:0]   w_op;
   logic [c_acc_w-1:0]   w_carry_sh;
   logic [c_acc_w-1:0]   w_csa_sum;
   logic [c_acc_w-1:0]   w_csa_carry;
   logic [c_acc_w-1:0]   w_total;
   logic [SUM_WIDTH-1:0] w_res_sum;
   logic                 w_res_co;

   assign w_accept = in_valid && (r_state == ST_ACCUM);
   assign w_close  = w_accept && (in_last || (r_count == c_last_cnt));
   assign w_xfer   = (r_state == ST_DONE) && out_ready;

   // 3:2 row: carry is kept unshifted and weighted by two wherever it is consumed
   assign w_op        = c_acc_w'(in_data);
   assign w_carry_sh  = r_cs_carry << 1;
   assign w_csa_sum   = r_cs_sum ^ w_carry_sh ^ w_op;
   assign w_csa_carry = (r_cs_sum & w_carry_sh) | (r_cs_sum & w_op) | (w_carry_sh & w_op);
   assign w_total     = r_cs_sum + w_carry_sh;

   generate
      if (SUM_WIDTH >= c_acc_w) begin : g_wide_sum
         assign w_res_sum = SUM_WIDTH'(w_total);
         assign w_res_co  = 1'b0;
      end else begin : g_narrow_sum
         assign w_res_sum = w_total[SUM_WIDTH-1:0];
         assign w_res_co  = |w_total[c_acc_w-1:SUM_WIDTH];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_ACCUM;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         ST_ACCUM: begin
            in_ready = 1'b1;
            if (w_close) begin
               w_state_nxt = ST_RESOLVE;
            end
         end
         ST_RESOLVE: begin
            w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = ST_ACCUM;
            end
         end
         default: begin
            w_state_nxt = ST_ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cs_sum    <= '0;
         r_cs_carry  <= '0;
         r_count     <= '0;
         r_out_sum   <= '0;
         r_out_co    <= 1'b0;
         r_out_count <= '0;
      end else begin
         if (w_accept) begin
            r_cs_sum   <= w_csa_sum;
            r_cs_carry <= w_csa_carry;
            r_count    <= r_count + CNT_WIDTH'(1);
         end
         if (r_state == ST_RESOLVE) begin
            r_out_sum   <= w_res_sum;
            r_out_co    <= w_res_co;
            r_out_count <= r_count;
         end
         // Output registers keep the last result; only the accumulator is cleared
         if (w_xfer) begin
            r_cs_sum   <= '0;
            r_cs_carry <= '0;
            r_count    <= '0;
         end
      end
   end

   assign out_sum   = r_out_sum;
   assign out_co    = r_out_co;
   assign out_count = r_out_count;

endmodule
`default_nettype wire
